// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants and helpers for the multiplexed seven-segment
// display scanner.
//   SEG_TABLE : 16-entry hex-to-segment table, active-low, bits g..a
//   SEG_BLANK : all segments dark
//   idx_width : counter/index width for a modulus of n (minimum 1 bit)
package fnd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry [15] is listed first: F, E, d, C, b, A, 9 .. 0
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h04, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h58, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic int idx_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/fnd_hex7.sv
// fnd_hex7: combinational hex nibble to seven-segment decoder.
//   nib   : 4-bit hex value
//   seg_n : active-low segments, bit6..bit0 = g,f,e,d,c,b,a
module fnd_hex7
  import fnd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[nib];

endmodule

// File: rtl/fnd_scan.sv
// fnd_scan: time-multiplexed seven-segment display scanner with a
// frame-synchronous load handshake (no mid-frame tearing).
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : scan enable (0 = dark, prescaler/index hold)
//   load        : one-cycle strobe capturing din / dp_in
//   din, dp_in  : hex nibbles (digit 0 = din[3:0]) and decimal points
//   seg_n, dp_n : registered active-low segments / decimal point
//   an_n        : registered active-low digit select
//   frame_done  : one-cycle pulse after each full scan
// Optional build macro FND_LZB_EN: blank leading zero digits (digit 0
// always shown, decimal points unaffected).
module fnd_scan
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int PW = idx_width(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc_r;
  logic [IW-1:0]           idx_r;
  logic [4*NUM_DIGITS-1:0] disp_r;
  logic [4*NUM_DIGITS-1:0] pend_r;
  logic [NUM_DIGITS-1:0]   disp_dp_r;
  logic [NUM_DIGITS-1:0]   pend_dp_r;
  logic                    pend_flag_r;
  logic [6:0]              seg_n_r;
  logic                    dp_n_r;
  logic [NUM_DIGITS-1:0]   an_n_r;
  logic                    frame_done_r;

  logic                    tc_s;
  logic                    wrap_s;
  logic [3:0]              nib_s;
  logic                    dp_sel_s;
  logic [NUM_DIGITS-1:0]   an_s;
  logic [6:0]              hex_seg_s;
  logic [6:0]              seg_s;
  logic                    blank_s;

  assign tc_s   = en && (presc_r == PRESC_MAX);
  assign wrap_s = tc_s && (idx_r == IDX_MAX);

  // Prescaler and digit index; both freeze while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
      idx_r   <= '0;
    end else if (tc_s) begin
      presc_r <= '0;
      idx_r   <= (idx_r == IDX_MAX) ? '0 : idx_r + IW'(1);
    end else if (en) begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Load handshake: pending data only reaches the display at a frame wrap;
  // a load landing exactly on the wrap bypasses the pending stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_r      <= '0;
      disp_dp_r   <= '0;
      pend_r      <= '0;
      pend_dp_r   <= '0;
      pend_flag_r <= 1'b0;
    end else if (wrap_s && load) begin
      disp_r      <= din;
      disp_dp_r   <= dp_in;
      pend_flag_r <= 1'b0;
    end else if (wrap_s) begin
      if (pend_flag_r) begin
        disp_r    <= pend_r;
        disp_dp_r <= pend_dp_r;
      end
      pend_flag_r <= 1'b0;
    end else if (load) begin
      pend_r      <= din;
      pend_dp_r   <= dp_in;
      pend_flag_r <= 1'b1;
    end
  end

  // Select the current digit's nibble, decimal point and anode
  always_comb begin
    nib_s    = 4'h0;
    dp_sel_s = 1'b0;
    an_s     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_r == IW'(i)) begin
        nib_s    = disp_r[4*i +: 4];
        dp_sel_s = disp_dp_r[i];
        an_s[i]  = 1'b0;
      end else begin
        an_s[i]  = 1'b1;
      end
    end
  end

  fnd_hex7 u_hex7 (
    .nib   (nib_s),
    .seg_n (hex_seg_s)
  );

`ifdef FND_LZB_EN
  logic [IW-1:0] msd_s;

  // Locate the most significant nonzero digit; anything above it is blank
  always_comb begin
    msd_s = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      msd_s = (disp_r[4*i +: 4] != 4'h0) ? IW'(i) : msd_s;
    end
    if (idx_r > msd_s) begin
      blank_s = 1'b1;
    end else begin
      blank_s = 1'b0;
    end
  end
`else
  assign blank_s = 1'b0;
`endif

  assign seg_s = blank_s ? SEG_BLANK : hex_seg_s;

  // Output registers: one clock behind the index, forced dark when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n_r      <= SEG_BLANK;
      dp_n_r       <= 1'b1;
      an_n_r       <= '1;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= wrap_s;
      if (en) begin
        seg_n_r <= seg_s;
        dp_n_r  <= ~dp_sel_s;
        an_n_r  <= an_s;
      end else begin
        seg_n_r <= SEG_BLANK;
        dp_n_r  <= 1'b1;
        an_n_r  <= '1;
      end
    end
  end

  assign seg_n      = seg_n_r;
  assign dp_n       = dp_n_r;
  assign an_n       = an_n_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_fnd_scan.sv
// tb_fnd_scan: scoreboard bench for fnd_scan (NUM_DIGITS=4, SCAN_DIV=4).
// Expected {an_n, seg_n, dp_n} per cycle are queued from a bench-side
// model when data is loaded, then popped one per clock and compared.
module tb_fnd_scan;

  localparam int ND = 4;
  localparam int SD = 4;
`ifdef FND_LZB_EN
  localparam bit LZB_ON = 1'b1;
`else
  localparam bit LZB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int total = 0;
  int passed = 0;
  logic [11:0] exp_q[$];

  fnd_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .din        (din),
    .dp_in      (dp_in),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h58;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h04;  default: return 7'h0E;
    endcase
  endfunction

  // Queue one full frame of expected pin states for display value d / dp
  task automatic push_frame(input logic [15:0] d, input logic [3:0] dp);
    int msd;
    logic [3:0] nib;
    logic [6:0] sg;
    logic [3:0] an;
    msd = 0;
    for (int i = 1; i < ND; i++) if (d[4*i +: 4] != 4'h0) msd = i;
    for (int i = 0; i < ND; i++) begin
      nib = d[4*i +: 4];
      sg  = (LZB_ON && (i > msd)) ? 7'h7F : hex_seg(nib);
      an  = ~(4'b0001 << i);
      for (int k = 0; k < SD; k++) exp_q.push_back({an, sg, ~dp[i]});
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    @(negedge clk);
    din = d; dp_in = dp; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1;
    #12;
    total++; if (an_n !== 4'b1111) $display("FAIL rst_an: got %b expected 1111", an_n); else passed++;
    total++; if (seg_n !== 7'h7F) $display("FAIL rst_seg: got %h expected 7f", seg_n); else passed++;
    total++; if (dp_n !== 1'b1) $display("FAIL rst_dp: got %b expected 1", dp_n); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL rst_fd: got %b expected 0", frame_done); else passed++;
    @(negedge clk); rst_n = 1'b1; #1;
    total++; if ({an_n, seg_n} !== {4'b1111, 7'h7F}) $display("FAIL rel_hold: got an=%b seg=%h expected an=1111 seg=7f", an_n, seg_n); else passed++;
    @(posedge clk); #1;
    total++; if ({an_n, seg_n, dp_n} !== {4'b1110, 7'h40, 1'b1}) $display("FAIL rel_first: got an=%b seg=%h dp=%b expected an=1110 seg=40 dp=1", an_n, seg_n, dp_n); else passed++;
  endtask

  task automatic test_display;
    bit ok;
    logic [11:0] e;
    do_load(16'h12AF, 4'b0000);
    wait_frame(ok);
    total++; if (!ok) $display("FAIL display_wait: got no frame_done expected pulse"); else passed++;
    push_frame(16'h12AF, 4'b0000);
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(posedge clk); #1; e = exp_q.pop_front();
      total++; if ({an_n, seg_n, dp_n} !== e) $display("FAIL display_%0d: got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b", n, an_n, seg_n, dp_n, e[11:8], e[7:1], e[0]); else passed++;
    end
  endtask

  task automatic test_overwrite;
    bit ok;
    logic [11:0] e;
    wait_frame(ok);
    repeat (4) @(posedge clk);
    do_load(16'h1111, 4'b0000);
    repeat (3) @(negedge clk);
    do_load(16'h2222, 4'b0000);
    wait_frame(ok);
    total++; if (!ok) $display("FAIL overwrite_wait: got no frame_done expected pulse"); else passed++;
    push_frame(16'h2222, 4'b0000);
    push_frame(16'h2222, 4'b0000);
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(posedge clk); #1; e = exp_q.pop_front();
      total++; if ({an_n, seg_n, dp_n} !== e) $display("FAIL overwrite_%0d: got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b", n, an_n, seg_n, dp_n, e[11:8], e[7:1], e[0]); else passed++;
    end
  endtask

  task automatic test_wrap_load;
    bit ok;
    logic [11:0] e;
    wait_frame(ok);
    total++; if (!ok) $display("FAIL wrapld_wait: got no frame_done expected pulse"); else passed++;
    repeat (15) @(posedge clk);
    @(negedge clk); din = 16'h3456; dp_in = 4'b0000; load = 1'b1;
    @(negedge clk); load = 1'b0;
    total++; if (frame_done !== 1'b1) $display("FAIL wrapld_period1: got %b expected 1", frame_done); else passed++;
    push_frame(16'h3456, 4'b0000);
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(posedge clk); #1; e = exp_q.pop_front();
      total++; if ({an_n, seg_n, dp_n} !== e) $display("FAIL wrapld_%0d: got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b", n, an_n, seg_n, dp_n, e[11:8], e[7:1], e[0]); else passed++;
      if (n < 15) begin
        total++; if (frame_done !== 1'b0) $display("FAIL wrapld_fd_low_%0d: got %b expected 0", n, frame_done); else passed++;
      end
    end
    total++; if (frame_done !== 1'b1) $display("FAIL wrapld_period2: got %b expected 1", frame_done); else passed++;
  endtask

  task automatic test_enable;
    bit ok;
    logic [11:0] e;
    wait_frame(ok);
    total++; if (!ok) $display("FAIL en_wait: got no frame_done expected pulse"); else passed++;
    repeat (9) @(posedge clk); #1;
    total++; if ({an_n, seg_n} !== {4'b1011, 7'h19}) $display("FAIL en_pre: got an=%b seg=%h expected an=1011 seg=19", an_n, seg_n); else passed++;
    @(negedge clk); en = 1'b0; din = 16'h9C0D; dp_in = 4'b0101; load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(posedge clk);
      #1;
      total++; if ({an_n, seg_n, dp_n, frame_done} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) $display("FAIL en_dark_%0d: got an=%b seg=%h dp=%b fd=%b expected an=1111 seg=7f dp=1 fd=0", n, an_n, seg_n, dp_n, frame_done); else passed++;
    end
    @(negedge clk); en = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back({4'b1011, 7'h19, 1'b1});
    for (int k = 0; k < 4; k++) exp_q.push_back({4'b0111, 7'h30, 1'b1});
    push_frame(16'h9C0D, 4'b0101);
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(posedge clk); #1; e = exp_q.pop_front();
      total++; if ({an_n, seg_n, dp_n} !== e) $display("FAIL en_resume_%0d: got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b", n, an_n, seg_n, dp_n, e[11:8], e[7:1], e[0]); else passed++;
    end
  endtask

  task automatic test_lzb;
    bit ok;
    logic [11:0] e;
    do_load(16'h0040, 4'b1000);
    wait_frame(ok);
    total++; if (!ok) $display("FAIL lzb_wait: got no frame_done expected pulse"); else passed++;
    push_frame(16'h0040, 4'b1000);
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(posedge clk); #1; e = exp_q.pop_front();
      total++; if ({an_n, seg_n, dp_n} !== e) $display("FAIL lzb_%0d: got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b", n, an_n, seg_n, dp_n, e[11:8], e[7:1], e[0]); else passed++;
    end
  endtask

  task automatic test_reset_pending;
    logic [11:0] e;
    do_load(16'h7777, 4'b1111);
    @(negedge clk); rst_n = 1'b0; #1;
    total++; if ({an_n, seg_n, dp_n, frame_done} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) $display("FAIL rstp_async: got an=%b seg=%h dp=%b fd=%b expected an=1111 seg=7f dp=1 fd=0", an_n, seg_n, dp_n, frame_done); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #1;
    total++; if ({an_n, seg_n} !== {4'b1111, 7'h7F}) $display("FAIL rstp_rel: got an=%b seg=%h expected an=1111 seg=7f", an_n, seg_n); else passed++;
    push_frame(16'h0000, 4'b0000);
    push_frame(16'h0000, 4'b0000);
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(posedge clk); #1; e = exp_q.pop_front();
      total++; if ({an_n, seg_n, dp_n} !== e) $display("FAIL rstp_%0d: got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b", n, an_n, seg_n, dp_n, e[11:8], e[7:1], e[0]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_display();
    test_overwrite();
    test_wrap_load();
    test_enable();
    test_lzb();
    test_reset_pending();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
